btn_event: RTL and testbench
============================

// Module: btn_event
// PURPOSE
//  Downstream of the button-matrix scanner. Samples its 20-bit key-state vector and debounces it.
//  Turns each accepted change into per-key press events, and release events when optional.
//  Queues events in a small FIFO with a valid/ready output to the CPU/IO-bus side.
// PARAMETERS
//  TICK_CYCLES    100000  clk cycles between samples of key_state (1 ms at 100 MHz); >=2
//  STABLE_SAMPLES 3       consecutive identical samples required to accept a vector; 1..15
//  FIFO_DEPTH     8       event FIFO entries; power of 2, >=2
// PORTS
//  clk        in   1   main clock
//  rst_n      in   1   asynchronous active-low reset
//  key_state  in   20  raw pressed-key vector from scanner, bit i = key i pressed
//  stable     out  20  debounced key vector
//  ev_valid   out  1   FIFO head event available
//  ev_ready   in   1   consumer accepts head when ev_valid&ev_ready
//  ev_code    out  5   key index 0..19 of head event
//  ev_press   out  1   1=press, 0=release
//  ev_count   out  4   FIFO occupancy 0..FIFO_DEPTH
// BEHAVIOUR
//  Reset (async, rst_n=0):
//  - stable=0, ev_valid=0, ev_code=0, ev_press=0, ev_count=0.
//  - Tick counter=0, candidate=0, match count=0, pending mask=0, FSM=IDLE.
//  Tick:
//  - Counter counts 0..TICK_CYCLES-1; tick=1 for one cycle at TICK_CYCLES-1, then counter wraps to 0.
//  Debounce (on tick only):
//  - If key_state==candidate, the match count increments, saturating at STABLE_SAMPLES.
//  - Otherwise candidate<=key_state and the match count<=1.
//  - Accept when the match count reaches STABLE_SAMPLES, candidate!=stable, and FSM=IDLE.
//  - On accept: pending<=candidate^stable, pol<=candidate, stable<=candidate (same cycle), FSM->EMIT.
//  - A candidate that meets the condition while FSM=EMIT is held. It is accepted on the first tick after return to IDLE if still valid.
//  FSM IDLE/EMIT:
//  - In EMIT, each cycle picks the lowest set bit i of pending, subject to the event filter.
//  - If the FIFO is not full: push {i, pol[i]} and clear pending[i].
//  - If the FIFO is full: stall, pending unchanged, no event lost.
//  - EMIT->IDLE the cycle after pending (filtered) becomes 0.
//  - Max throughput 1 event/cycle; an event is visible on ev_valid 1 cycle after push.
//  FIFO:
//  - Registered head; ev_code/ev_press hold stable while ev_valid&!ev_ready.
//  - Simultaneous push+pop when full is legal; pop frees the slot first, count unchanged.
//  - Pop when empty is ignored.
//  - ev_count wraps never; pointers are log2(FIFO_DEPTH)+1 bits.
//  Other:
//  - key_state is not synchronised here; the scanner output is already registered in clk domain.
//  - Reset asserted mid-EMIT discards pending and the FIFO contents immediately.
// CONFIGURATION
//  BTN_RELEASE_EVT_EN
//  - Defined: release edges (pending bit with pol=0) emit events with ev_press=0.
//  - Undefined: the release bits of pending are masked off at accept, and only presses are queued.
//  - Undefined: stable still tracks releases, and ev_press is always 1 when ev_valid.
// TESTING
//  (sim params TICK_CYCLES=4, STABLE_SAMPLES=3, FIFO_DEPTH=4)
//  1. key_state=0x00001 held 12+ cycles
//     -> stable=0x00001 after 3rd matching tick; one event code=0 press=1.
//  2. key_state toggles 0x00010/0 every tick
//     -> stable stays 0, no events, ev_count=0.
//  3. 0 -> 0xF0000 with ev_ready=0
//     -> codes 16,17 queued then... 16,17,18,19 fill FIFO (count=4); ev_ready=1 drains in order 16,17,18,19.
//  4. 0 -> 0x0003F with ev_ready=0
//     -> 4 queued, EMIT stalls; raise ev_ready -> codes 4,5 follow; no loss, count never >4.
//  5. press 0x00100 then release to 0
//     -> with BTN_RELEASE_EVT_EN: (8,1),(8,0); without: only (8,1).
//  6. rst_n pulsed low mid-EMIT with 3 events queued
//     -> ev_valid=0, ev_count=0, stable=0 same cycle; no events until new stable change.

Source files
------------

// File: rtl/btn_event_if.sv
// Event-queue handshake between btn_event (master) and the CPU/IO-bus consumer (slave).
interface btn_event_if;
   logic       ev_valid;
   logic       ev_ready;
   logic [4:0] ev_code;
   logic       ev_press;
   logic [3:0] ev_count;

   modport master (output ev_valid, ev_code, ev_press, ev_count, input ev_ready);
   modport slave  (input ev_valid, ev_code, ev_press, ev_count, output ev_ready);
endinterface

// File: rtl/btn_event.sv
// Debounces the scanner's 20-bit key vector and queues per-key press/release events.
// Release events are emitted only when BTN_RELEASE_EVT_EN is defined.
//
//  state | meaning
//  IDLE  | waiting for a debounced change of the key vector
//  EMIT  | pushing one event per cycle from the pending mask into the FIFO
module btn_event #(
   parameter int TICK_CYCLES    = 100000,
   parameter int STABLE_SAMPLES = 3,
   parameter int FIFO_DEPTH     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [19:0]      key_state,
   output logic [19:0]      stable,
   btn_event_if.master      ev
);

   localparam int TW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t      state, state_nxt;
   logic [TW-1:0] tick_cnt;
   logic        tick;
   logic [19:0] cand, cand_nxt;
   logic [3:0]  match, match_nxt;
   logic [19:0] pending, pol, accept_mask;
   logic        accept;
   logic [4:0]  sel;
   logic        push, pop, full;

   logic [4:0]  fifo_code [FIFO_DEPTH];
   logic        fifo_pol  [FIFO_DEPTH];
   logic [AW:0] wr_ptr, rd_ptr, count;

   assign tick = (tick_cnt == TW'(TICK_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    tick_cnt <= '0;
      else if (tick) tick_cnt <= '0;
      else           tick_cnt <= tick_cnt + 1'b1;
   end

   // Next debounce state is what the current tick will store; accept looks at it
   // so the vector is taken on the same tick that completes the run of samples.
   always_comb begin
      cand_nxt  = cand;
      match_nxt = match;
      if (key_state == cand) begin
         if (match < 4'(STABLE_SAMPLES)) match_nxt = match + 4'd1;
      end else begin
         cand_nxt  = key_state;
         match_nxt = 4'd1;
      end
   end

   assign accept = tick && (state == IDLE) && (match_nxt == 4'(STABLE_SAMPLES))
                   && (cand_nxt != stable);

`ifdef BTN_RELEASE_EVT_EN
   assign accept_mask = cand_nxt ^ stable;
`else
   assign accept_mask = (cand_nxt ^ stable) & cand_nxt;
`endif

   always_comb begin
      sel = 5'd0;
      for (int i = 19; i >= 0; i--) begin
         if (pending[i]) sel = 5'(i);
      end
   end

   assign count = wr_ptr - rd_ptr;
   assign full  = (count == (AW+1)'(FIFO_DEPTH));
   assign pop   = ev.ev_valid && ev.ev_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // A pop in the same cycle frees the head slot, so a full FIFO does not stall then.
   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      case (state)
         IDLE: if (accept) state_nxt = EMIT;
         EMIT: begin
            if (pending == '0)      state_nxt = IDLE;
            else if (!full || pop)  push = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand    <= '0;
         match   <= '0;
         stable  <= '0;
         pending <= '0;
         pol     <= '0;
      end else begin
         if (tick) begin
            cand  <= cand_nxt;
            match <= match_nxt;
         end
         if (accept) begin
            stable  <= cand_nxt;
            pending <= accept_mask;
            pol     <= cand_nxt;
         end else if (push) begin
            pending <= pending & ~(20'd1 << sel);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_code[i] <= '0;
            fifo_pol[i]  <= 1'b0;
         end
      end else begin
         if (push) begin
            fifo_code[wr_ptr[AW-1:0]] <= sel;
            fifo_pol[wr_ptr[AW-1:0]]  <= pol[sel];
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   assign ev.ev_valid = (count != '0);
   assign ev.ev_code  = fifo_code[rd_ptr[AW-1:0]];
   assign ev.ev_press = fifo_pol[rd_ptr[AW-1:0]];
   assign ev.ev_count = 4'(count);

endmodule

// File: tb/tb_btn_event.sv
// Scoreboard bench for btn_event with TICK_CYCLES=4, STABLE_SAMPLES=3, FIFO_DEPTH=4.
module tb_btn_event;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [19:0] key_state = '0;
   logic [19:0] stable;

   btn_event_if ev ();

   btn_event #(.TICK_CYCLES(4), .STABLE_SAMPLES(3), .FIFO_DEPTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_state (key_state),
      .stable    (stable),
      .ev        (ev)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [5:0]  sb [$];
   logic [19:0] cur_keys = '0;
   int          max_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Expected events for a change of the debounced vector, lowest key first.
   task automatic set_keys(input logic [19:0] nw);
      for (int i = 0; i < 20; i++) begin
         if (nw[i] != cur_keys[i]) begin
            if (nw[i]) sb.push_back({5'(i), 1'b1});
`ifdef BTN_RELEASE_EVT_EN
            else       sb.push_back({5'(i), 1'b0});
`endif
         end
      end
      key_state = nw;
      cur_keys  = nw;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag);
      cyc(20);
      for (int i = 0; i < 300 && sb.size() != 0; i++) cyc(1);
      chk(tag, 32'(sb.size()), 32'd0);
   endtask

   task automatic wait_count(input string tag, input int n);
      for (int i = 0; i < 100 && int'(ev.ev_count) != n; i++) cyc(1);
      chk(tag, 32'(ev.ev_count), 32'(n));
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (int'(ev.ev_count) > max_cnt) max_cnt = int'(ev.ev_count);
         if (ev.ev_valid && ev.ev_ready) begin
            if (sb.size() == 0) chk("unexpected_event", 32'({ev.ev_code, ev.ev_press}), 32'hFFFF_FFFF);
            else                chk("event", 32'({ev.ev_code, ev.ev_press}), 32'(sb.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      ev.ev_ready = 1'b1;
      key_state   = 20'h00001;
      cyc(3);
      chk("rst_stable", 32'(stable), 32'd0);
      chk("rst_valid",  32'(ev.ev_valid), 32'd0);
      chk("rst_count",  32'(ev.ev_count), 32'd0);
      chk("rst_code",   32'(ev.ev_code), 32'd0);
      chk("rst_press",  32'(ev.ev_press), 32'd0);

      // 1: ticks land on the 4th, 8th, 12th edge after release; accept on the 3rd one
      key_state = 20'h0;
      set_keys(20'h00001);
      rst_n = 1'b1;
      cyc(11);
      chk("t1_before_accept", 32'(stable), 32'd0);
      cyc(1);
      chk("t1_accept", 32'(stable), 32'h00001);
      drain("t1_drain");

      // 2: a key chattering on every tick never settles
      for (int i = 0; i < 8; i++) begin
         key_state = (i % 2 == 0) ? 20'h00011 : 20'h00001;
         cyc(4);
      end
      key_state = 20'h00001;
      cyc(20);
      chk("t2_stable", 32'(stable), 32'h00001);
      chk("t2_count",  32'(ev.ev_count), 32'd0);
      chk("t2_sb",     32'(sb.size()), 32'd0);
      set_keys(20'h0);
      drain("t1_release_drain");
      chk("t1_release_stable", 32'(stable), 32'd0);

      // 3: four presses fill the FIFO exactly, head holds while not ready
      ev.ev_ready = 1'b0;
      set_keys(20'hF0000);
      wait_count("t3_fill", 4);
      chk("t3_head_code",  32'(ev.ev_code), 32'd16);
      chk("t3_head_press", 32'(ev.ev_press), 32'd1);
      cyc(10);
      chk("t3_hold_code",  32'(ev.ev_code), 32'd16);
      chk("t3_hold_count", 32'(ev.ev_count), 32'd4);
      ev.ev_ready = 1'b1;
      drain("t3_drain");
      chk("t3_empty", 32'(ev.ev_count), 32'd0);
      set_keys(20'h0);
      drain("t3_release_drain");

      // 4: six presses against a four-entry FIFO stall EMIT without loss
      ev.ev_ready = 1'b0;
      max_cnt = 0;
      set_keys(20'h0003F);
      wait_count("t4_fill", 4);
      cyc(12);
      chk("t4_stall_count", 32'(ev.ev_count), 32'd4);
      chk("t4_stall_code",  32'(ev.ev_code), 32'd0);
      ev.ev_ready = 1'b1;
      drain("t4_drain");
      chk("t4_max_le4", 32'(max_cnt <= 4), 32'd1);
      chk("t4_max_hit", 32'(max_cnt), 32'd4);
      set_keys(20'h0);
      drain("t4_release_drain");

      // 5: press then release of key 8
      set_keys(20'h00100);
      drain("t5_press_drain");
      set_keys(20'h0);
      drain("t5_release_drain");
      chk("t5_stable", 32'(stable), 32'd0);

      // 6: reset in the middle of emitting discards everything at once
      ev.ev_ready = 1'b0;
      set_keys(20'h0001F);
      wait_count("t6_three", 3);
      rst_n = 1'b0;
      key_state = 20'h0;
      cur_keys  = 20'h0;
      sb.delete();
      #1;
      chk("t6_rst_valid",  32'(ev.ev_valid), 32'd0);
      chk("t6_rst_count",  32'(ev.ev_count), 32'd0);
      chk("t6_rst_stable", 32'(stable), 32'd0);
      cyc(2);
      rst_n = 1'b1;
      ev.ev_ready = 1'b1;
      cyc(40);
      chk("t6_quiet_count", 32'(ev.ev_count), 32'd0);
      chk("t6_quiet_valid", 32'(ev.ev_valid), 32'd0);
      set_keys(20'h00002);
      drain("t6_new_drain");
      chk("t6_new_stable", 32'(stable), 32'h00002);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
